// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: the data width, the funct3
// width/sign encodings, the FSM state type and the request fault check.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_t;

  // A request faults on an unsupported width or an address that is not
  // naturally aligned for that width.
  function automatic logic is_fault(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] off);
    logic bad_f3;
    logic misaligned;
    if (we) bad_f3 = (funct3 >= 3'b011);
    else    bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                 ((funct3[1:0] == 2'b10) && (off != 2'b00));
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane handling: extract-and-extend for loads, and the
// merge of narrow store data into the word read back from memory.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext,
  output logic [XLEN-1:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    ext    = '0;
    case (funct3)
      F3_B:    ext = {{24{lane_b[7]}}, lane_b};
      F3_H:    ext = {{16{lane_h[15]}}, lane_h};
      F3_W:    ext = word;
      F3_BU:   ext = {24'd0, lane_b};
      F3_HU:   ext = {16'd0, lane_h};
      default: ext = '0;
    endcase
  end

  always_comb begin
    merged = word;
    if (funct3 == F3_B) begin
      merged[{off, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_H) begin
      if (off[1]) merged[31:16] = wdata[15:0];
      else        merged[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding request FSM driving a word-wide,
// combinational-read data memory without byte enables.
module lsu
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state, state_next;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            fault_q;
  logic [XLEN-1:0] lane_ext;
  logic [XLEN-1:0] lane_merged;
  logic            accept;
  logic            req_fault;

  assign accept    = (state == S_IDLE) && req_valid;
  assign req_fault = is_fault(req_we, req_funct3, req_addr[1:0]);

  lsu_lane u_lane (
    .word   (mem_rdata),
    .wdata  (wdata_q),
    .off    (off_q),
    .funct3 (f3_q),
    .ext    (lane_ext),
    .merged (lane_merged)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req_valid) state_next = req_fault ? S_RESP : S_ACCESS;
      S_ACCESS: state_next = (!we_q || f3_q == F3_W) ? S_RESP : S_WRITE;
      S_WRITE:  state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Faulted requests go straight to RESP, so they can never reach a write state.
  assign mem_we     = ((state == S_ACCESS) && we_q && (f3_q == F3_W)) ||
                      (state == S_WRITE);
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        addr_q  <= {req_addr[XLEN-1:2], 2'b00};
        wdata_q <= req_wdata;
        rdata_q <= '0;
        fault_q <= req_fault;
      end else if (state == S_ACCESS) begin
        if (!we_q)              rdata_q <= lane_ext;
        else if (f3_q != F3_W)  wdata_q <= lane_merged;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small word memory model and hand-computed
// expected results for loads, stores, faults and reset behaviour.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  int total = 0;
  int fails = 0;

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request, then watches up to 8 cycles after the accept edge.
  // lat = cycle index of resp_valid (-1 if none), we_at = first mem_we cycle.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int we_cnt,
                         output int we_at, output logic [31:0] rdata, output logic fault,
                         output logic [31:0] wa, output logic [31:0] wd);
    lat = -1; we_cnt = 0; we_at = -1; rdata = 'x; fault = 1'bx; wa = 'x; wd = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin
        if (we_at < 0) we_at = n;
        we_cnt++; wa = mem_addr; wd = mem_wdata;
      end
      if (resp_valid) begin
        lat = n; rdata = resp_rdata; fault = resp_fault;
        break;
      end
    end
  endtask

  int lat, we_cnt, we_at;
  logic [31:0] rdata, wa, wd;
  logic fault;
  int seen_resp;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h8899AABB;
    mem[12] = 32'h11223344;

    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    req_valid = 1'b0;
    rst_n = 1'b1;

    run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("first_lw_lat", lat, 2);
    chk("first_lw_data", rdata, 32'h8899AABB);

    run_req(1'b0, 3'b000, 32'h13, 32'h0, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("lb_lat", lat, 2);
    chk("lb_data", rdata, 32'hFFFFFF88);
    chk("lb_fault", {31'd0, fault}, 32'd0);
    run_req(1'b0, 3'b100, 32'h13, 32'h0, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("lbu_data", rdata, 32'h00000088);
    run_req(1'b0, 3'b001, 32'h10, 32'h0, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("lh_data", rdata, 32'hFFFFAABB);
    run_req(1'b0, 3'b101, 32'h12, 32'h0, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("lhu_data", rdata, 32'h00008899);

    run_req(1'b1, 3'b000, 32'h11, 32'h123456CC, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("sb_lat", lat, 3);
    chk("sb_we_cnt", we_cnt, 1);
    chk("sb_we_at", we_at, 2);
    chk("sb_mem_addr", wa, 32'h10);
    chk("sb_mem_wdata", wd, 32'h8899CCBB);
    chk("sb_rdata", rdata, 32'h0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("lw_after_sb", rdata, 32'h8899CCBB);

    run_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("sw_we_at", we_at, 1);
    chk("sw_we_cnt", we_cnt, 1);
    chk("sw_lat", lat, 2);
    chk("sw_mem_wdata", wd, 32'hDEADBEEF);
    run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("lw_after_sw", rdata, 32'hDEADBEEF);
    chk("lw_after_sw_fault", {31'd0, fault}, 32'd0);

    run_req(1'b0, 3'b010, 32'h22, 32'h0, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_fault", {31'd0, fault}, 32'd1);
    chk("lw_mis_rdata", rdata, 32'h0);
    chk("lw_mis_we", we_cnt, 0);
    run_req(1'b1, 3'b001, 32'h21, 32'h0000BEEF, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("sh_mis_fault", {31'd0, fault}, 32'd1);
    chk("sh_mis_rdata", rdata, 32'h0);
    chk("sh_mis_we", we_cnt, 0);
    chk("sh_mis_mem", mem[8], 32'hDEADBEEF);
    run_req(1'b0, 3'b011, 32'h10, 32'h0, lat, we_cnt, we_at, rdata, fault, wa, wd);
    chk("ld011_fault", {31'd0, fault}, 32'd1);
    chk("ld011_rdata", rdata, 32'h0);
    chk("ld011_we", we_cnt, 0);

    // SH 0x30 interrupted by reset while the merged word is being written.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h30; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("shrst_access_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("shrst_write_we", {31'd0, mem_we}, 32'd1);
    chk("shrst_write_wdata", mem_wdata, 32'h1122BEEF);
    #1 rst_n = 1'b0;
    #1 chk("shrst_we_drop", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("shrst_mem", mem[12], 32'h11223344);
    chk("shrst_ready", {31'd0, req_ready}, 32'd1);
    seen_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
    end
    chk("shrst_no_resp", seen_resp, 0);
    chk("shrst_mem_final", mem[12], 32'h11223344);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
